// File: rtl/irq_dispatch.sv
// Interrupt dispatch stage: collects bank events into pending registers, feeds the
// priority encoder, and runs the irq / cpu_ack / eoi handshake with the CPU.
module irq_dispatch #(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] evt_a,
    input  logic [8:0] evt_b,
    input  logic [8:0] evt_c,
    input  logic       glb_en,
    output logic [8:0] req_a,
    output logic [8:0] req_b,
    output logic [8:0] req_c,
    input  logic       enc_pa,
    input  logic       enc_pb,
    input  logic       enc_pc,
    input  logic [3:0] enc_chan,
    output logic       irq,
    output logic [5:0] irq_vec,
    input  logic       cpu_ack,
    input  logic       eoi,
    output logic       busy,
    output logic       err,
    output logic [7:0] tmo_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state, next_state;
    logic [8:0] pend_a, pend_b, pend_c;
    logic [8:0] clr_a, clr_b, clr_c;
    logic [7:0] ack_cnt;
    logic [5:0] vec_q;
    logic [1:0] enc_bank;
    logic       enc_any;
    logic       enc_illegal;
    logic       do_latch;
    logic       do_clear;
    logic       do_tmo;
    logic       err_set;

    assign enc_any     = enc_pa | enc_pb | enc_pc;
    assign enc_illegal = (enc_chan > 4'd8) ||
                         (enc_pa & enc_pb) || (enc_pa & enc_pc) || (enc_pb & enc_pc);
    assign enc_bank    = enc_pa ? 2'd0 : (enc_pb ? 2'd1 : 2'd2);

    always_comb begin
        next_state = state;
        do_latch   = 1'b0;
        do_clear   = 1'b0;
        do_tmo     = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (glb_en && enc_any) begin
                    if (enc_illegal) begin
                        err_set = 1'b1;
                    end else begin
                        do_latch   = 1'b1;
                        next_state = ASSERT;
                    end
                end
            end
            ASSERT: begin
                // Ack beats both a withdraw and a coincident timeout.
                if (cpu_ack) begin
                    do_clear   = 1'b1;
                    next_state = SERVICE;
                end else if (!glb_en) begin
                    next_state = IDLE;
                end else if (ack_cnt == TMO_LAST) begin
                    do_tmo     = 1'b1;
                    next_state = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        clr_a = '0;
        clr_b = '0;
        clr_c = '0;
        if (do_clear && vec_q[3:0] <= 4'd8) begin
            case (vec_q[5:4])
                2'd0:    clr_a[vec_q[3:0]] = 1'b1;
                2'd1:    clr_b[vec_q[3:0]] = 1'b1;
                2'd2:    clr_c[vec_q[3:0]] = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend_a  <= '0;
            pend_b  <= '0;
            pend_c  <= '0;
            ack_cnt <= '0;
            vec_q   <= '0;
            err     <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state  <= next_state;
            // A set in the same cycle as the clear keeps the bit pending.
            pend_a <= (pend_a & ~clr_a) | evt_a;
            pend_b <= (pend_b & ~clr_b) | evt_b;
            pend_c <= (pend_c & ~clr_c) | evt_c;
            if (do_latch) begin
                vec_q   <= {enc_bank, enc_chan};
                ack_cnt <= '0;
            end else if (state == ASSERT) begin
                ack_cnt <= ack_cnt + 8'd1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
            if (do_tmo && tmo_cnt != 8'hFF) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

    assign req_a   = pend_a;
    assign req_b   = pend_b;
    assign req_c   = pend_c;
    assign irq     = (state == ASSERT);
    assign busy    = (state != IDLE);
    assign irq_vec = vec_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed bench for irq_dispatch with a behavioural priority encoder in the loop.
module tb_irq_dispatch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] evt_a, evt_b, evt_c;
    logic       glb_en;
    logic [8:0] req_a, req_b, req_c;
    logic       enc_pa, enc_pb, enc_pc;
    logic [3:0] enc_chan;
    logic       irq;
    logic [5:0] irq_vec;
    logic       cpu_ack, eoi;
    logic       busy, err;
    logic [7:0] tmo_cnt;
    logic       force_ill;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_dispatch #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .evt_a(evt_a), .evt_b(evt_b), .evt_c(evt_c),
        .glb_en(glb_en),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .enc_pa(enc_pa), .enc_pb(enc_pb), .enc_pc(enc_pc), .enc_chan(enc_chan),
        .irq(irq), .irq_vec(irq_vec),
        .cpu_ack(cpu_ack), .eoi(eoi),
        .busy(busy), .err(err), .tmo_cnt(tmo_cnt)
    );

    function automatic logic [3:0] lowest(input logic [8:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 8; i >= 0; i--) if (v[i]) r = 4'(i);
        return r;
    endfunction

    // Encoder model: bank A > B > C, lowest channel index wins.
    always_comb begin
        enc_pa = 1'b0; enc_pb = 1'b0; enc_pc = 1'b0; enc_chan = '0;
        if (force_ill) begin
            enc_pa = 1'b1; enc_chan = 4'hB;
        end else if (|req_a) begin
            enc_pa = 1'b1; enc_chan = lowest(req_a);
        end else if (|req_b) begin
            enc_pb = 1'b1; enc_chan = lowest(req_b);
        end else if (|req_c) begin
            enc_pc = 1'b1; enc_chan = lowest(req_c);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_irq(input string tag, input int budget);
        int n = 0;
        while (irq !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (irq !== 1'b1) check(tag, 32'(irq), 32'd1);
    endtask

    task automatic serve(input string tag, input logic [5:0] vec);
        wait_irq({tag, "_irq"}, 10);
        check({tag, "_vec"}, 32'(irq_vec), 32'(vec));
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        check({tag, "_busy_svc"}, 32'(busy), 32'd1);
        check({tag, "_irq_svc"}, 32'(irq), 32'd0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; glb_en = 1'b0; force_ill = 1'b0;
        evt_a = '0; evt_b = '0; evt_c = '0; cpu_ack = 1'b0; eoi = 1'b0;
        repeat (3) tick();
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'({req_a, req_b, req_c}), 32'd0);
        check("rst_err_tmo", 32'({err, tmo_cnt}), 32'd0);
        rst_n = 1'b1;
        glb_en = 1'b1;
        tick();

        // Single event B/5
        evt_b[5] = 1'b1;
        tick();
        evt_b = '0;
        check("single_req", 32'(req_b[5]), 32'd1);
        check("single_irq_lat1", 32'(irq), 32'd0);
        tick();
        check("single_irq_lat2", 32'(irq), 32'd1);
        check("single_vec", 32'(irq_vec), 32'h15);
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        check("single_req_clr", 32'(req_b[5]), 32'd0);
        check("single_busy", 32'(busy), 32'd1);
        check("single_irq_drop", 32'(irq), 32'd0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check("single_idle", 32'(busy), 32'd0);
        tick();

        // Priority order
        evt_c[0] = 1'b1; evt_a[8] = 1'b1; evt_a[2] = 1'b1;
        tick();
        evt_a = '0; evt_c = '0;
        serve("prio0", 6'h02);
        serve("prio1", 6'h08);
        serve("prio2", 6'h20);
        check("prio_empty", 32'({req_a, req_b, req_c}), 32'd0);

        // Set wins over clear
        evt_a[3] = 1'b1;
        tick();
        evt_a = '0;
        wait_irq("setw_irq", 10);
        check("setw_vec", 32'(irq_vec), 32'h03);
        cpu_ack = 1'b1; evt_a[3] = 1'b1;
        tick();
        cpu_ack = 1'b0; evt_a = '0;
        check("setw_req", 32'(req_a[3]), 32'd1);
        check("setw_busy", 32'(busy), 32'd1);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        serve("setw_again", 6'h03);
        check("setw_req_gone", 32'(req_a[3]), 32'd0);

        // Ack timeout, ACK_TIMEOUT = 4
        evt_a[1] = 1'b1;
        tick();
        evt_a = '0;
        wait_irq("tmo_irq", 10);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("tmo_high_%0d_%0d", r, i), 32'(irq), 32'd1);
                tick();
            end
            check($sformatf("tmo_low_%0d", r), 32'(irq), 32'd0);
            check($sformatf("tmo_cnt_%0d", r), 32'(tmo_cnt), 32'(r + 1));
            check($sformatf("tmo_keep_%0d", r), 32'(req_a[1]), 32'd1);
            tick();
            check($sformatf("tmo_retry_%0d", r), 32'(irq), 32'd1);
        end
        serve("tmo_serve", 6'h01);
        check("tmo_final", 32'(tmo_cnt), 32'd2);

        // Withdraw on glb_en drop
        evt_b[2] = 1'b1;
        tick();
        evt_b = '0;
        wait_irq("wd_irq", 10);
        glb_en = 1'b0;
        tick();
        check("wd_irq_drop", 32'(irq), 32'd0);
        check("wd_keep", 32'(req_b[2]), 32'd1);
        tick();
        check("wd_no_dispatch", 32'(irq), 32'd0);
        check("wd_tmo", 32'(tmo_cnt), 32'd2);
        glb_en = 1'b1;
        serve("wd_serve", 6'h12);

        // Illegal encoder output
        force_ill = 1'b1;
        tick();
        check("ill_err", 32'(err), 32'd1);
        check("ill_irq", 32'(irq), 32'd0);
        tick();
        check("ill_busy", 32'(busy), 32'd0);
        force_ill = 1'b0;
        evt_c[7] = 1'b1;
        tick();
        evt_c = '0;
        serve("ill_legal", 6'h27);
        check("ill_sticky", 32'(err), 32'd1);

        // Async reset during ASSERT
        evt_b[0] = 1'b1; evt_c[4] = 1'b1;
        tick();
        evt_b = '0; evt_c = '0;
        wait_irq("ar_irq", 10);
        #2 rst_n = 1'b0;
        #1;
        check("ar_irq", 32'(irq), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_req", 32'({req_a, req_b, req_c}), 32'd0);
        check("ar_err_tmo", 32'({err, tmo_cnt}), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("ar_quiet_%0d", i), 32'({irq, busy}), 32'd0);
        end
        evt_a[4] = 1'b1;
        tick();
        evt_a = '0;
        serve("ar_new", 6'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/irq_dispatch.md
# irq_dispatch

Sequential dispatch stage that sits on both sides of the 27-channel priority interrupt encoder. It collects interrupt events from three 9-bit source banks (A, B, C) into pending registers and drives them onto the encoder's request inputs. It takes the encoder's bank-select and channel outputs, runs the request/acknowledge/end-of-interrupt handshake with the CPU, and clears each served request.

## Interface
- `ACK_TIMEOUT`, default 64: cycles irq may stay high without `cpu_ack` before it is withdrawn (legal range 2..255).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset. Deassertion is synchronous to `clk`.
- `evt_a` / `evt_b` / `evt_c` in 9 each: one-cycle set pulses, one per channel.
- `glb_en` in 1: global enable. Driven straight to the encoder enable and gates dispatch.
- `req_a` / `req_b` / `req_c` out 9 each: pending bits, driven to the encoder request buses.
- `enc_pa` / `enc_pb` / `enc_pc` in 1 each: encoder winner-bank flags, at most one high. Bank priority is A > B > C.
- `enc_chan` in 4: winning channel index 0..8 within the flagged bank. Index 0 is highest priority.
- `irq` out 1: interrupt request to the CPU.
- `irq_vec` out 6: `{bank[1:0], chan[3:0]}`, with bank codes A=0, B=1, C=2. Valid while `irq`=1 or state is SERVICE.
- `cpu_ack` in 1: one-cycle acknowledge.
- `eoi` in 1: one-cycle end-of-interrupt.
- `busy` out 1: high in ASSERT or SERVICE.
- `err` out 1: sticky flag for an illegal encoder output. Cleared only by reset.
- `tmo_cnt` out 8: saturating count of ack timeouts.

## Operation
**Pending registers (27 bits)**
- An `evt` bit sets the matching pending bit.
- A clear happens only on accept, for the bit named by the latched `irq_vec`.
- If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays pending.
- `req_*` are the pending registers themselves, registered outputs with no combinational path from `evt`.

**State machine**
- IDLE: `irq`=0, `busy`=0.
  - If `glb_en`=1 and any `enc_p*`=1, latch `irq_vec` from the encoder outputs and go to ASSERT.
  - Illegal encoder output means `enc_chan`>8, or more than one `enc_p*` high. In that case set `err` and stay in IDLE (no latch).
- ASSERT: `irq`=1. The timeout counter loads 0 on entry and increments each cycle.
  - `cpu_ack`=1: clear the latched pending bit, go to SERVICE. `irq` drops on the next edge.
  - Counter reaches `ACK_TIMEOUT`-1 without ack: `tmo_cnt` += 1 (saturates at 255), go to IDLE. The pending bit is kept for retry.
  - `glb_en`=0: withdraw to IDLE. Pending bit kept, no timeout counted.
- SERVICE: `irq`=0, `busy`=1, `irq_vec` held. No new dispatch (no nesting).
  - `eoi`=1: go to IDLE.
  - `cpu_ack` in SERVICE is ignored.
- `eoi` outside SERVICE is ignored.
- `cpu_ack` and the timeout in the same cycle: ack wins.
- When the bit is cleared on ack, the encoder re-resolves from the remaining pending bits. The next dispatch happens only after return to IDLE.

**Reset**
- All outputs are 0, including `err` and `tmo_cnt`. Pending registers are 0. State is IDLE.
- Reset mid-handshake drops `irq` immediately (asynchronous) and discards all pending requests.

## Timing
- An `evt` sampled at edge N makes the pending bit and `req_*` high after edge N.
- The encoder is combinational. With IDLE and `glb_en`=1, edge N+1 latches `irq_vec` and `irq` is high after N+1. Event-to-`irq` latency is 2 edges.
- `cpu_ack` sampled at edge M: the pending bit clears and `irq`=0 after M; state is SERVICE.
- `eoi` sampled at edge K: IDLE after K. The earliest next `irq` is after K+1.
- Timeout with no ack: `irq` is high for exactly `ACK_TIMEOUT` cycles. The re-dispatch `irq` rises 2 edges after the drop (one IDLE cycle, one latch).
- Minimum full cycle: `irq` high 1 cycle (ack the same cycle it is seen), SERVICE at least 1 cycle.

## Test plan
- **Single event.** Reset, `glb_en`=1, pulse `evt_b[5]`, encoder model returns B/5.
  - `irq`=1 two edges later with `irq_vec`=6'h15.
  - Ack: `req_b[5]`=0, `busy`=1.
  - `eoi`: `busy`=0.
- **Priority order.** `evt_c[0]`, `evt_a[8]`, `evt_a[2]` in the same cycle.
  - Dispatch order is 6'h02, then 6'h08, then 6'h20, each after `eoi`.
- **Set wins over clear.** Pulse `evt_a[3]` in the same cycle as the `cpu_ack` for A/3.
  - `req_a[3]` stays 1.
  - After `eoi`, A/3 is dispatched again.
- **Ack timeout.** `ACK_TIMEOUT`=4, never ack.
  - `irq` high 4 cycles, then low 1 cycle, then high again; `tmo_cnt`=1, then 2.
  - The pending bit is retained throughout.
- **Illegal encoder output.** Force `enc_pa`=1 with `enc_chan`=4'hB.
  - `err`=1 and `irq` stays 0.
  - `err` is still 1 after legal traffic resumes, and is cleared only by `rst_n`.
- **Async reset during ASSERT.** Assert `rst_n`=0 between clock edges.
  - `irq`, `req_*`, `busy` go 0 immediately.
  - After release, no `irq` occurs until a new event arrives.
